// File: rtl/systolic_ctrl_pkg.sv
// Shared types and helpers for the systolic array control blocks.
package systolic_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CMP,
    SETTLE,
    SELECT,
    OUT,
    DONE
  } readout_state_t;

  // Index width that never collapses to zero bits for degenerate sizes.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int flat_idx(input int r, input int c, input int n);
    return r * n + c;
  endfunction

endpackage

// File: rtl/readout_idx_counter.sv
// Row-major raster counter over the N x N PE grid; exposes the value the
// registers will hold after this cycle so callers can pre-compute selects.
module readout_idx_counter
  import systolic_ctrl_pkg::*;
#(
  parameter int N  = 32,
  parameter int IW = idx_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          advance,
  output logic [IW-1:0] row,
  output logic [IW-1:0] col,
  output logic [IW-1:0] nxt_row,
  output logic [IW-1:0] nxt_col,
  output logic          last
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  always_comb begin
    nxt_row = row;
    nxt_col = col;
    if (clear) begin
      nxt_row = '0;
      nxt_col = '0;
    end else if (advance) begin
      if (col == LAST_IDX) begin
        nxt_col = '0;
        nxt_row = row + IW'(1);
      end else begin
        nxt_col = col + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else begin
      row <= nxt_row;
      col <= nxt_col;
    end
  end

  assign last = (row == LAST_IDX) && (col == LAST_IDX);

endmodule

// File: rtl/accumulator_readout_ctrl.sv
// Drains the systolic array accumulators PE by PE in row-major order and
// streams each captured value out on a valid/ready port tagged with row/col.
module accumulator_readout_ctrl
  import systolic_ctrl_pkg::*;
#(
  parameter int N              = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SETTLE_CYCLES  = 10,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic                       mult_complete_i,
  input  logic [N*N-1:0]             acc_valid_i,
  input  logic [DATA_WIDTH-1:0]      rd_data_i,
  output logic [N*N-1:0]             select_o,
  output logic [idx_width(N)-1:0]    sel_row_o,
  output logic [idx_width(N)-1:0]    sel_col_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DATA_WIDTH-1:0]      out_data_o,
  output logic [idx_width(N)-1:0]    out_row_o,
  output logic [idx_width(N)-1:0]    out_col_o,
  output logic                       out_last_o,
  output logic                       out_err_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [$clog2(N*N+1)-1:0]   err_count_o
);

  localparam int IW = idx_width(N);
  localparam int NN = N * N;
  localparam int EW = $clog2(NN + 1);
  localparam int TW = idx_width(TIMEOUT_CYCLES);
  localparam int SW = idx_width(SETTLE_CYCLES);

  readout_state_t state, state_nxt;
  logic [IW-1:0]  row, col, nxt_row, nxt_col;
  logic           idx_last;
  logic           start_seq, cnt_adv, hit, timeout, capture;
  logic [TW-1:0]  tcnt;
  logic [SW-1:0]  scnt;
  logic [NN-1:0]  cur_sel, nxt_sel;

  readout_idx_counter #(.N(N), .IW(IW)) u_idx (
    .clk     (clk_i),
    .rst_n   (rstn_i),
    .clear   (start_seq),
    .advance (cnt_adv),
    .row     (row),
    .col     (col),
    .nxt_row (nxt_row),
    .nxt_col (nxt_col),
    .last    (idx_last)
  );

  assign sel_row_o = row;
  assign sel_col_o = col;
  assign cur_sel   = NN'(1) << flat_idx(int'(row), int'(col), N);
  assign nxt_sel   = NN'(1) << flat_idx(int'(nxt_row), int'(nxt_col), N);

  // Abort overrides every transition, including a start seen in IDLE.
  always_comb begin
    state_nxt = state;
    start_seq = 1'b0;
    cnt_adv   = 1'b0;
    hit       = |(acc_valid_i & cur_sel);
    timeout   = (int'(tcnt) == TIMEOUT_CYCLES - 1);
    if (abort_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state_nxt = WAIT_CMP;
            start_seq = 1'b1;
          end
        end
        WAIT_CMP: begin
          if (mult_complete_i) state_nxt = (SETTLE_CYCLES == 0) ? SELECT : SETTLE;
        end
        SETTLE: begin
          if (int'(scnt) == SETTLE_CYCLES - 1) state_nxt = SELECT;
        end
        SELECT: begin
          if (hit || timeout) state_nxt = OUT;
        end
        OUT: begin
          if (out_ready_i) begin
            if (out_last_o) begin
              state_nxt = DONE;
            end else begin
              state_nxt = SELECT;
              cnt_adv   = 1'b1;
            end
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign capture = (state == SELECT) && (state_nxt == OUT);

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      tcnt        <= '0;
      scnt        <= '0;
      select_o    <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_row_o   <= '0;
      out_col_o   <= '0;
      out_last_o  <= 1'b0;
      out_err_o   <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_count_o <= '0;
    end else begin
      state       <= state_nxt;
      busy_o      <= (state_nxt != IDLE);
      done_o      <= (state_nxt == DONE);
      out_valid_o <= (state_nxt == OUT);
      select_o    <= (state_nxt == SELECT) ? nxt_sel : '0;
      tcnt        <= ((state == SELECT) && (state_nxt == SELECT)) ? tcnt + TW'(1) : '0;
      scnt        <= (state == SETTLE) ? scnt + SW'(1) : '0;
      if (capture) begin
        out_data_o <= hit ? rd_data_i : '0;
        out_err_o  <= !hit;
        out_row_o  <= row;
        out_col_o  <= col;
        out_last_o <= idx_last;
      end
      if (start_seq) begin
        err_count_o <= '0;
      end else if (capture && !hit && (err_count_o != '1)) begin
        err_count_o <= err_count_o + EW'(1);
      end
    end
  end

endmodule

// File: tb/tb_accumulator_readout_ctrl.sv
// Randomized bench for accumulator_readout_ctrl: an array/sink model reacts to
// select_o and collects words, which are compared with a row-major model.
module tb_accumulator_readout_ctrl;

  localparam int N      = 4;
  localparam int NN     = N * N;
  localparam int DW     = 32;
  localparam int SETTLE = 2;
  localparam int TMO    = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    row;
    logic [1:0]    col;
    logic          last;
    logic          err;
  } word_t;

  logic          clk = 1'b0;
  logic          rstn_i = 1'b0;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic          mult_complete_i = 1'b0;
  logic [NN-1:0] acc_valid_i = '0;
  logic [DW-1:0] rd_data_i = '0;
  logic          out_ready_i = 1'b0;
  logic [NN-1:0] select_o;
  logic [1:0]    sel_row_o, sel_col_o, out_row_o, out_col_o;
  logic          out_valid_o, out_last_o, out_err_o, busy_o, done_o;
  logic [DW-1:0] out_data_o;
  logic [4:0]    err_count_o;

  int tests_run = 0;
  int tests_failed = 0;

  bit            ready_rand = 1'b0, ready_low = 1'b0, noise_en = 1'b0, dead_en = 1'b0;
  int            dead_idx = 0;
  int            delay [NN];
  logic [DW-1:0] pe_data [NN];
  word_t         words [$];
  word_t         cur_word, prev_word;
  bit            prev_stall = 1'b0;
  logic [NN-1:0] prev_sel = '0;
  int            cyc = 0, age = 0, cmp_cyc = 0, first_sel_cyc = -1, done_cyc = -1;
  int            done_cnt = 0, onehot_viol = 0, overlap_viol = 0, stab_viol = 0;
  int            sel_pulses [NN];
  int            last_age [NN];

  accumulator_readout_ctrl #(
    .N(N), .DATA_WIDTH(DW), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .rstn_i(rstn_i), .start_i(start_i), .abort_i(abort_i),
    .mult_complete_i(mult_complete_i), .acc_valid_i(acc_valid_i), .rd_data_i(rd_data_i),
    .select_o(select_o), .sel_row_o(sel_row_o), .sel_col_o(sel_col_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_row_o(out_row_o), .out_col_o(out_col_o), .out_last_o(out_last_o),
    .out_err_o(out_err_o), .busy_o(busy_o), .done_o(done_o), .err_count_o(err_count_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Array and sink model: drives ready, answers selects after a per-PE delay
  // with junk data until valid, sprinkles valid noise on unselected PEs.
  always @(negedge clk) begin
    int k;
    cyc++;
    if (ready_low) out_ready_i = 1'b0;
    else if (ready_rand) out_ready_i = 1'($urandom_range(0, 1));
    else out_ready_i = 1'b1;
    cur_word = {out_data_o, out_row_o, out_col_o, out_last_o, out_err_o};
    if (prev_stall && (!out_valid_o || cur_word !== prev_word)) stab_viol++;
    prev_stall = out_valid_o && !out_ready_i;
    prev_word  = cur_word;
    if (out_valid_o && out_ready_i) words.push_back(cur_word);
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if ($countones(select_o) > 1) onehot_viol++;
    if (select_o != '0 && out_valid_o) overlap_viol++;
    k = -1;
    for (int i = 0; i < NN; i++) if (select_o[i]) k = i;
    acc_valid_i = noise_en ? (NN'($urandom) & ~select_o) : '0;
    rd_data_i = $urandom;
    if (k >= 0) begin
      if (select_o != prev_sel) begin
        age = 1;
        sel_pulses[k]++;
      end else begin
        age++;
      end
      last_age[k] = age;
      if (first_sel_cyc < 0) first_sel_cyc = cyc;
      if (!(dead_en && k == dead_idx) && age == delay[k]) begin
        acc_valid_i[k] = 1'b1;
        rd_data_i = pe_data[k];
      end else begin
        rd_data_i = ~pe_data[k];
      end
    end else begin
      age = 0;
    end
    prev_sel = select_o;
  end

  function automatic word_t model_word(input int k);
    word_t w;
    bit dead;
    dead   = dead_en && (k == dead_idx);
    w.data = dead ? '0 : pe_data[k];
    w.row  = 2'(k / N);
    w.col  = 2'(k % N);
    w.last = (k == NN - 1);
    w.err  = dead;
    return w;
  endfunction

  task automatic clear_stats();
    words.delete();
    done_cnt = 0; onehot_viol = 0; overlap_viol = 0; stab_viol = 0;
    first_sel_cyc = -1; done_cyc = -1; prev_stall = 1'b0;
    for (int i = 0; i < NN; i++) begin
      sel_pulses[i] = 0;
      last_age[i] = 0;
    end
  endtask

  task automatic randomize_pes();
    for (int i = 0; i < NN; i++) begin
      pe_data[i] = $urandom;
      delay[i]   = $urandom_range(1, 6);
    end
  endtask

  task automatic run_seq(input int cmp_delay, input bit extra_starts, output bit timed_out);
    timed_out = 1'b1;
    @(negedge clk); #1;
    clear_stats();
    start_i = 1'b1;
    @(negedge clk); #1;
    start_i = 1'b0;
    repeat (cmp_delay) @(negedge clk);
    #1;
    mult_complete_i = 1'b1;
    cmp_cyc = cyc;
    if (extra_starts) begin
      @(negedge clk); #1; start_i = 1'b1;
      @(negedge clk); #1; start_i = 1'b0;
      for (int i = 0; i < 500; i++) begin
        @(negedge clk); #1;
        if (select_o[5]) break;
      end
      start_i = 1'b1;
      @(negedge clk); #1; start_i = 1'b0;
    end
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (done_o) begin
        timed_out = 1'b0;
        break;
      end
    end
    repeat (6) @(negedge clk);
    #1;
    mult_complete_i = 1'b0;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (select_o !== '0) begin tests_failed++; $display("[TB] FAIL reset select_o: got %h want 0", select_o); end
    tests_run++;
    if ({out_valid_o, busy_o, done_o, out_last_o, out_err_o} !== 5'b0) begin
      tests_failed++; $display("[TB] FAIL reset flags: got %b want 00000", {out_valid_o, busy_o, done_o, out_last_o, out_err_o});
    end
    tests_run++;
    if ({out_data_o, out_row_o, out_col_o, sel_row_o, sel_col_o, err_count_o} !== '0) begin
      tests_failed++; $display("[TB] FAIL reset data/idx: got %h want 0", {out_data_o, out_row_o, out_col_o, sel_row_o, sel_col_o, err_count_o});
    end
    @(negedge clk);
    rstn_i = 1'b1;
  endtask

  task automatic test_basic();
    bit to;
    for (int i = 0; i < NN; i++) begin
      pe_data[i] = DW'(16 * (i / N) + (i % N));
      delay[i]   = 1;
    end
    ready_rand = 1'b0; noise_en = 1'b0; dead_en = 1'b0;
    run_seq(5, 1'b0, to);
    tests_run++;
    if (to) begin tests_failed++; $display("[TB] FAIL basic done timeout: got none want done_o"); end
    tests_run++;
    if (words.size() != NN) begin tests_failed++; $display("[TB] FAIL basic word count: got %0d want %0d", words.size(), NN); end
    for (int k = 0; k < NN && k < words.size(); k++) begin
      tests_run++;
      if (words[k] !== model_word(k)) begin
        tests_failed++; $display("[TB] FAIL basic word %0d: got %h want %h", k, words[k], model_word(k));
      end
    end
    for (int k = 0; k < NN; k++) begin
      tests_run++;
      if (sel_pulses[k] != 1 || last_age[k] != 1) begin
        tests_failed++; $display("[TB] FAIL basic select PE%0d: got pulses=%0d cycles=%0d want 1/1", k, sel_pulses[k], last_age[k]);
      end
    end
    tests_run++;
    if (done_cnt != 1) begin tests_failed++; $display("[TB] FAIL basic done count: got %0d want 1", done_cnt); end
    tests_run++;
    if (first_sel_cyc != cmp_cyc + SETTLE + 1) begin
      tests_failed++; $display("[TB] FAIL basic settle latency: got %0d want %0d", first_sel_cyc - cmp_cyc, SETTLE + 1);
    end
    tests_run++;
    if (done_cyc - first_sel_cyc != 2 * NN) begin
      tests_failed++; $display("[TB] FAIL basic throughput: got %0d want %0d", done_cyc - first_sel_cyc, 2 * NN);
    end
    tests_run++;
    if (onehot_viol != 0 || overlap_viol != 0) begin
      tests_failed++; $display("[TB] FAIL basic select shape: got onehot=%0d overlap=%0d want 0/0", onehot_viol, overlap_viol);
    end
    tests_run++;
    if (err_count_o !== 5'd0) begin tests_failed++; $display("[TB] FAIL basic err_count: got %0d want 0", err_count_o); end
  endtask

  task automatic test_backpressure();
    bit to;
    randomize_pes();
    ready_rand = 1'b1; noise_en = 1'b1; dead_en = 1'b0;
    run_seq(3, 1'b0, to);
    tests_run++;
    if (to) begin tests_failed++; $display("[TB] FAIL bp done timeout: got none want done_o"); end
    tests_run++;
    if (words.size() != NN) begin tests_failed++; $display("[TB] FAIL bp word count: got %0d want %0d", words.size(), NN); end
    for (int k = 0; k < NN && k < words.size(); k++) begin
      tests_run++;
      if (words[k] !== model_word(k) || last_age[k] != delay[k]) begin
        tests_failed++; $display("[TB] FAIL bp word %0d: got %h after %0d cycles want %h after %0d", k, words[k], last_age[k], model_word(k), delay[k]);
      end
    end
    tests_run++;
    if (stab_viol != 0) begin tests_failed++; $display("[TB] FAIL bp stall stability: got %0d changes want 0", stab_viol); end
    tests_run++;
    if (done_cnt != 1 || overlap_viol != 0) begin
      tests_failed++; $display("[TB] FAIL bp done/overlap: got %0d/%0d want 1/0", done_cnt, overlap_viol);
    end
  endtask

  task automatic test_timeout();
    bit to;
    randomize_pes();
    ready_rand = 1'b1; noise_en = 1'b1; dead_en = 1'b1; dead_idx = 2 * N + 1;
    run_seq(2, 1'b0, to);
    tests_run++;
    if (to) begin tests_failed++; $display("[TB] FAIL timeout done timeout: got none want done_o"); end
    tests_run++;
    if (words.size() != NN) begin tests_failed++; $display("[TB] FAIL timeout word count: got %0d want %0d", words.size(), NN); end
    for (int k = 0; k < NN && k < words.size(); k++) begin
      tests_run++;
      if (words[k] !== model_word(k)) begin
        tests_failed++; $display("[TB] FAIL timeout word %0d: got %h want %h", k, words[k], model_word(k));
      end
    end
    tests_run++;
    if (last_age[dead_idx] != TMO) begin
      tests_failed++; $display("[TB] FAIL timeout select cycles: got %0d want %0d", last_age[dead_idx], TMO);
    end
    tests_run++;
    if (err_count_o !== 5'd1) begin tests_failed++; $display("[TB] FAIL timeout err_count: got %0d want 1", err_count_o); end
  endtask

  task automatic test_abort();
    bit to, found;
    randomize_pes();
    ready_rand = 1'b1; noise_en = 1'b1; dead_en = 1'b1; dead_idx = 2;
    @(negedge clk); #1;
    clear_stats();
    start_i = 1'b1;
    @(negedge clk); #1;
    start_i = 1'b0;
    mult_complete_i = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); #1;
      if (select_o[1 * N + 3]) begin
        found = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!found) begin tests_failed++; $display("[TB] FAIL abort reach PE[1][3]: got no select want select"); end
    abort_i = 1'b1;
    @(negedge clk); #1;
    abort_i = 1'b0;
    tests_run++;
    if ({select_o != '0, out_valid_o, busy_o} !== 3'b000) begin
      tests_failed++; $display("[TB] FAIL abort outputs: got sel=%h valid=%b busy=%b want 0/0/0", select_o, out_valid_o, busy_o);
    end
    tests_run++;
    if (err_count_o !== 5'd1) begin tests_failed++; $display("[TB] FAIL abort err_count kept: got %0d want 1", err_count_o); end
    repeat (10) @(negedge clk);
    #1;
    tests_run++;
    if (done_cnt != 0 || busy_o !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL abort stays idle: got done=%0d busy=%b want 0/0", done_cnt, busy_o);
    end
    mult_complete_i = 1'b0;
    dead_en = 1'b0;
    run_seq(4, 1'b0, to);
    tests_run++;
    if (to || words.size() != NN) begin
      tests_failed++; $display("[TB] FAIL abort rerun: got timeout=%b words=%0d want 0/%0d", to, words.size(), NN);
    end
    for (int k = 0; k < NN && k < words.size(); k++) begin
      tests_run++;
      if (words[k] !== model_word(k)) begin
        tests_failed++; $display("[TB] FAIL abort rerun word %0d: got %h want %h", k, words[k], model_word(k));
      end
    end
    tests_run++;
    if (err_count_o !== 5'd0 || done_cnt != 1) begin
      tests_failed++; $display("[TB] FAIL abort rerun err/done: got %0d/%0d want 0/1", err_count_o, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit to, found;
    randomize_pes();
    ready_rand = 1'b1; noise_en = 1'b1; dead_en = 1'b1; dead_idx = 0;
    @(negedge clk); #1;
    clear_stats();
    start_i = 1'b1;
    @(negedge clk); #1;
    start_i = 1'b0;
    mult_complete_i = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); #1;
      if (out_valid_o && out_row_o == 2'd1 && out_col_o == 2'd1) begin
        found = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!found || err_count_o !== 5'd1) begin
      tests_failed++; $display("[TB] FAIL midreset precondition: got found=%b err_count=%0d want 1/1", found, err_count_o);
    end
    #2 rstn_i = 1'b0;
    #1;
    tests_run++;
    if ({select_o != '0, out_valid_o, busy_o, done_o, out_last_o, out_err_o} !== 6'b0) begin
      tests_failed++; $display("[TB] FAIL midreset flags: got %b want 000000", {select_o != '0, out_valid_o, busy_o, done_o, out_last_o, out_err_o});
    end
    tests_run++;
    if ({out_data_o, out_row_o, out_col_o, sel_row_o, sel_col_o, err_count_o} !== '0) begin
      tests_failed++; $display("[TB] FAIL midreset data/idx: got %h want 0", {out_data_o, out_row_o, out_col_o, sel_row_o, sel_col_o, err_count_o});
    end
    mult_complete_i = 1'b0;
    @(negedge clk);
    rstn_i = 1'b1;
    dead_en = 1'b0;
    run_seq(3, 1'b1, to);
    tests_run++;
    if (to || done_cnt != 1) begin
      tests_failed++; $display("[TB] FAIL start ignored done: got timeout=%b done=%0d want 0/1", to, done_cnt);
    end
    tests_run++;
    if (words.size() != NN) begin tests_failed++; $display("[TB] FAIL start ignored count: got %0d want %0d", words.size(), NN); end
    for (int k = 0; k < NN && k < words.size(); k++) begin
      tests_run++;
      if (words[k] !== model_word(k)) begin
        tests_failed++; $display("[TB] FAIL start ignored word %0d: got %h want %h", k, words[k], model_word(k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
